// File: rtl/mux_scan_reg.sv
// rtl/mux_scan_reg.sv - registered N-channel word mux with direct and scan modes
module mux_scan_reg #(
    parameter int WIDTH    = 8,
    parameter int SEL_BITS = 3
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [(2**SEL_BITS)*WIDTH-1:0]    in_data,
    input  logic [SEL_BITS-1:0]               sel,
    input  logic [(2**SEL_BITS)-1:0]          en_mask,
    input  logic                              mode,
    input  logic                              in_valid,
    output logic                              in_ready,
    output logic [WIDTH-1:0]                  out_data,
    output logic [SEL_BITS-1:0]               out_ch,
    output logic                              out_last,
    output logic                              out_valid,
    input  logic                              out_ready
);

    localparam int N = 2**SEL_BITS;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SCAN = 1'b1;

    logic [0:0]          state_q,    state_d;
    logic [N*WIDTH-1:0]  snap_q,     snap_d;
    logic [N-1:0]        mask_q,     mask_d;
    logic [WIDTH-1:0]    out_data_q, out_data_d;
    logic [SEL_BITS-1:0] out_ch_q,   out_ch_d;
    logic                out_last_q, out_last_d;
    logic                out_valid_q, out_valid_d;

    logic                accept;
    logic                drain;
    logic [SEL_BITS-1:0] first_ch;
    logic [N-1:0]        first_rest;
    logic [SEL_BITS-1:0] next_ch;
    logic [N-1:0]        next_rest;

    // Index of the lowest set bit; callers only use it when the mask is non-zero.
    function automatic logic [SEL_BITS-1:0] lowest_set(input logic [N-1:0] m);
        lowest_set = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (m[i]) begin
                lowest_set = SEL_BITS'(i);
            end
        end
    endfunction

    // Mask bits strictly above idx; the search never wraps back to channel 0.
    function automatic logic [N-1:0] bits_above(input logic [N-1:0] m,
                                                input logic [SEL_BITS-1:0] idx);
        bits_above = '0;
        for (int i = 0; i < N; i++) begin
            if (i > int'(idx)) begin
                bits_above[i] = m[i];
            end
        end
    endfunction

    assign in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign drain    = out_valid_q && out_ready;

    assign first_ch   = lowest_set(en_mask);
    assign first_rest = bits_above(en_mask, first_ch);
    assign next_ch    = lowest_set(bits_above(mask_q, out_ch_q));
    assign next_rest  = bits_above(mask_q, next_ch);

    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_last  = out_last_q;
    assign out_valid = out_valid_q;

    // Next-state logic: accept new requests in IDLE, walk the snapshot in SCAN.
    always_comb begin
        state_d     = state_q;
        snap_d      = snap_q;
        mask_d      = mask_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q;

        if (state_q == IDLE) begin
            if (accept) begin
                if (!mode) begin
                    out_data_d  = in_data[sel*WIDTH +: WIDTH];
                    out_ch_d    = sel;
                    out_last_d  = 1'b1;
                    out_valid_d = 1'b1;
                end else if (en_mask != '0) begin
                    snap_d      = in_data;
                    mask_d      = en_mask;
                    out_data_d  = in_data[first_ch*WIDTH +: WIDTH];
                    out_ch_d    = first_ch;
                    out_valid_d = 1'b1;
                    if (first_rest == '0) begin
                        out_last_d = 1'b1;
                    end else begin
                        out_last_d = 1'b0;
                        state_d    = SCAN;
                    end
                end else begin
                    // Empty scan: request is consumed; the register was empty or draining.
                    out_valid_d = 1'b0;
                end
            end else if (drain) begin
                out_valid_d = 1'b0;
            end
        end else begin
            // In SCAN the current word is never the last, so a higher channel exists.
            if (drain) begin
                out_data_d  = snap_q[next_ch*WIDTH +: WIDTH];
                out_ch_d    = next_ch;
                out_valid_d = 1'b1;
                if (next_rest == '0) begin
                    out_last_d = 1'b1;
                    state_d    = IDLE;
                end else begin
                    out_last_d = 1'b0;
                end
            end
        end
    end

    // State and output registers; reset discards any scan in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            snap_q      <= '0;
            mask_q      <= '0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            snap_q      <= snap_d;
            mask_q      <= mask_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_mux_scan_reg.sv
// tb/tb_mux_scan_reg.sv - directed self-checking bench for mux_scan_reg
module tb_mux_scan_reg;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] in_data;
    logic [2:0]  sel;
    logic [7:0]  en_mask;
    logic        mode;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_data;
    logic [2:0]  out_ch;
    logic        out_last;
    logic        out_valid;
    logic        out_ready;

    int errors = 0;
    int checks = 0;

    mux_scan_reg #(.WIDTH(8), .SEL_BITS(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .sel       (sel),
        .en_mask   (en_mask),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_data(input logic [7:0] base);
        for (int k = 0; k < 8; k++) in_data[k*8 +: 8] = base + 8'(k);
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; mode = 1'b0;
        sel = '0; en_mask = '0; load_data(8'h10);
        tick(); tick();
        checks++; if (out_valid !== 1'b0) begin $display("FAIL reset_valid got=%b exp=0", out_valid); errors++; end
        checks++; if (out_data !== 8'h00) begin $display("FAIL reset_data got=%h exp=00", out_data); errors++; end
        checks++; if (out_ch !== 3'd0 || out_last !== 1'b0) begin $display("FAIL reset_ch_last got=%0d/%b exp=0/0", out_ch, out_last); errors++; end
        reset = 1'b0; #1;
        checks++; if (in_ready !== 1'b1) begin $display("FAIL reset_in_ready got=%b exp=1", in_ready); errors++; end
    endtask

    task automatic test_direct();
        mode = 1'b0; sel = 3'd5; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h15 || out_ch !== 3'd5 || out_last !== 1'b1) begin
            $display("FAIL direct_sel5 got=%b/%h/%0d/%b exp=1/15/5/1", out_valid, out_data, out_ch, out_last); errors++; end
        for (int i = 0; i < 8; i++) begin
            sel = 3'(i);
            #1;
            checks++; if (in_ready !== 1'b1) begin $display("FAIL b2b_in_ready[%0d] got=%b exp=1", i, in_ready); errors++; end
            tick();
            checks++; if (out_valid !== 1'b1 || out_data !== 8'h10 + 8'(i) || out_ch !== 3'(i) || out_last !== 1'b1) begin
                $display("FAIL b2b_word[%0d] got=%b/%h/%0d/%b exp=1/%h/%0d/1", i, out_valid, out_data, out_ch, out_last, 8'h10 + 8'(i), i); errors++; end
        end
        in_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0) begin $display("FAIL direct_drain got=%b exp=0", out_valid); errors++; end
    endtask

    task automatic test_full_scan();
        mode = 1'b1; en_mask = 8'hFF; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        load_data(8'hA0);
        for (int i = 0; i < 8; i++) begin
            #1;
            checks++; if (out_valid !== 1'b1 || out_ch !== 3'(i) || out_data !== 8'h10 + 8'(i) || out_last !== (i == 7)) begin
                $display("FAIL scan_word[%0d] got=%b/%0d/%h/%b exp=1/%0d/%h/%b", i, out_valid, out_ch, out_data, out_last, i, 8'h10 + 8'(i), i == 7); errors++; end
            checks++; if (in_ready !== (i == 7)) begin $display("FAIL scan_in_ready[%0d] got=%b exp=%b", i, in_ready, i == 7); errors++; end
            tick();
        end
        checks++; if (out_valid !== 1'b0) begin $display("FAIL scan_end_valid got=%b exp=0", out_valid); errors++; end
        load_data(8'h10);
    endtask

    task automatic test_sparse_empty();
        logic [2:0] exp_ch [3];
        exp_ch[0] = 3'd2; exp_ch[1] = 3'd5; exp_ch[2] = 3'd7;
        mode = 1'b1; en_mask = 8'b1010_0100; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int j = 0; j < 3; j++) begin
            checks++; if (out_valid !== 1'b1 || out_ch !== exp_ch[j] || out_data !== 8'h10 + 8'(exp_ch[j]) || out_last !== (j == 2)) begin
                $display("FAIL sparse_word[%0d] got=%b/%0d/%h/%b exp=1/%0d/%h/%b", j, out_valid, out_ch, out_data, out_last, exp_ch[j], 8'h10 + 8'(exp_ch[j]), j == 2); errors++; end
            tick();
        end
        checks++; if (out_valid !== 1'b0) begin $display("FAIL sparse_end got=%b exp=0", out_valid); errors++; end

        en_mask = 8'h01; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b1 || out_ch !== 3'd0 || out_data !== 8'h10 || out_last !== 1'b1) begin
            $display("FAIL single_word got=%b/%0d/%h/%b exp=1/0/10/1", out_valid, out_ch, out_data, out_last); errors++; end
        checks++; if (in_ready !== 1'b1) begin $display("FAIL single_idle got=%b exp=1", in_ready); errors++; end
        tick();
        checks++; if (out_valid !== 1'b0) begin $display("FAIL single_end got=%b exp=0", out_valid); errors++; end

        en_mask = 8'h00; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int j = 0; j < 3; j++) begin
            checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                $display("FAIL empty_mask[%0d] got=%b/%b exp=0/1", j, out_valid, in_ready); errors++; end
            tick();
        end
    endtask

    task automatic test_backpressure();
        logic       pat [4];
        int         exp_ch;
        int         cyc;
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        mode = 1'b1; en_mask = 8'hFF; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        exp_ch = 0; cyc = 0;
        while (exp_ch < 8 && cyc < 40) begin
            checks++; if (out_valid !== 1'b1 || out_ch !== 3'(exp_ch) || out_data !== 8'h10 + 8'(exp_ch) || out_last !== (exp_ch == 7)) begin
                $display("FAIL bp_word[c%0d] got=%b/%0d/%h/%b exp=1/%0d/%h/%b", cyc, out_valid, out_ch, out_data, out_last, exp_ch, 8'h10 + 8'(exp_ch), exp_ch == 7); errors++; end
            out_ready = pat[cyc % 4];
            #1;
            checks++; if (in_ready !== ((exp_ch == 7) ? out_ready : 1'b0)) begin
                $display("FAIL bp_in_ready[c%0d] got=%b exp=%b", cyc, in_ready, (exp_ch == 7) ? out_ready : 1'b0); errors++; end
            tick();
            if (out_ready) exp_ch++;
            cyc++;
        end
        checks++; if (exp_ch != 8) begin $display("FAIL bp_timeout got=%0d exp=8", exp_ch); errors++; end
        checks++; if (out_valid !== 1'b0) begin $display("FAIL bp_end got=%b exp=0", out_valid); errors++; end
        out_ready = 1'b1;
    endtask

    task automatic test_overlap();
        mode = 1'b1; en_mask = 8'hFF; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        out_ready = 1'b0; mode = 1'b0; sel = 3'd3; in_valid = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin $display("FAIL ovl_stall_ready got=%b exp=0", in_ready); errors++; end
        tick();
        checks++; if (out_valid !== 1'b1 || out_ch !== 3'd7 || out_data !== 8'h17 || out_last !== 1'b1) begin
            $display("FAIL ovl_hold got=%b/%0d/%h/%b exp=1/7/17/1", out_valid, out_ch, out_data, out_last); errors++; end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin $display("FAIL ovl_ready_rise got=%b exp=1", in_ready); errors++; end
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_ch !== 3'd3 || out_data !== 8'h13 || out_last !== 1'b1) begin
            $display("FAIL ovl_direct got=%b/%0d/%h/%b exp=1/3/13/1", out_valid, out_ch, out_data, out_last); errors++; end
        tick();
        checks++; if (out_valid !== 1'b0) begin $display("FAIL ovl_end got=%b exp=0", out_valid); errors++; end
    endtask

    task automatic test_reset_mid_scan();
        mode = 1'b1; en_mask = 8'hFF; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        checks++; if (out_ch !== 3'd3 || out_valid !== 1'b1) begin $display("FAIL mid_pre got=%0d/%b exp=3/1", out_ch, out_valid); errors++; end
        reset = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || out_data !== 8'h00 || out_ch !== 3'd0 || out_last !== 1'b0) begin
            $display("FAIL mid_reset got=%b/%h/%0d/%b exp=0/00/0/0", out_valid, out_data, out_ch, out_last); errors++; end
        tick();
        reset = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin $display("FAIL mid_in_ready got=%b exp=1", in_ready); errors++; end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (out_valid !== 1'b0) begin $display("FAIL mid_no_words[%0d] got=%b exp=0", i, out_valid); errors++; end
        end
    endtask

    initial begin
        test_reset();
        test_direct();
        test_full_scan();
        test_sparse_empty();
        test_backpressure();
        test_overlap();
        test_reset_mid_scan();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mux_scan_reg.md
# mux_scan_reg

Parametrised, registered N-channel word multiplexer for the ALU datapath. It generalises the 8:1 single-bit gate-level select to 2^SEL_BITS channels of WIDTH bits each, behind a valid/ready handshake on both sides. It has two modes:
- **Direct mode** forwards one selected channel per transaction.
- **Scan mode** snapshots all channels and emits every enabled channel in ascending order, one word per cycle.

It sits between the ALU result bus and the result/writeback stage.

## Interface
Parameters:
- WIDTH, default 8: bits per channel word.
- SEL_BITS, default 3: select width. N = 2^SEL_BITS channels.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- in_data  in  N*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- sel  in  SEL_BITS  channel index (direct mode).
- en_mask  in  N  channel enables (scan mode); bit k enables channel k.
- mode  in  1  0 = direct, 1 = scan.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid && in_ready.
- out_data  out  WIDTH  registered output word.
- out_ch  out  SEL_BITS  channel index of out_data.
- out_last  out  1  marks the final word of a transaction.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accepts the word when out_valid && out_ready.

## Operation
State machine:
- IDLE:
  - in_ready = !out_valid || out_ready. The output register is empty or draining this cycle.
  - On accept, sel, en_mask and mode are sampled.
- Accept with mode=0:
  - out_data <= in_data[sel].
  - out_ch <= sel, out_last <= 1, out_valid <= 1.
  - State stays IDLE.
- Accept with mode=1 and en_mask != 0:
  - All N words are copied into an internal N*WIDTH snapshot buffer, and the mask is stored.
  - The lowest enabled channel is loaded into the output register in the same edge.
  - If no other channel is enabled, out_last <= 1 and the state stays IDLE. Otherwise out_last <= 0 and the state goes to SCAN.
- Accept with mode=1 and en_mask == 0:
  - The request is consumed and nothing is emitted.
  - out_valid follows normal drain rules. State stays IDLE.
- SCAN:
  - in_ready = 0. in_data changes are ignored; the snapshot is used.
  - On each output transfer, the register loads the next enabled channel above the current out_ch, taken from the snapshot.
  - out_last = 1 on the highest enabled channel.
  - When the last word is loaded, the state returns to IDLE, so a new request can be accepted while that last word drains.
- Stall: while out_valid && !out_ready, out_data, out_ch, out_last and the state hold.
- Channel index search never wraps past N-1. A scan ends at the highest enabled channel.
- Reset at any time, including mid-scan:
  - state = IDLE.
  - out_valid, out_last, out_data and out_ch go to 0.
  - The snapshot is discarded.
  - in_ready is 1 on the first cycle after reset.

## Timing
- Direct latency: 1 cycle. Accept at edge t gives out_valid from t.
- Scan latency: the first word is valid 1 cycle after accept. With out_ready held at 1, there is one word per cycle. A full-mask scan occupies N consecutive cycles, and the next request can be accepted in the cycle of the N-th word.
- Back-to-back direct transactions: 1 per cycle with out_ready=1.
- in_ready is combinational from state, out_valid and out_ready only. There is no path from in_valid.
- All outputs are registered except in_ready.

## Test plan
- **Reset:** assert reset mid-scan (after 3 of 8 words).
  - Required: immediately out_valid=0, out_data=0, out_ch=0, out_last=0.
  - Required: in_ready=1 after release, and no further scan words.
- **Direct mode:** in_data channel k = 8'h10+k, mode=0, sel=5, out_ready=1.
  - Required: next cycle out_data=8'h15, out_ch=5, out_last=1.
  - Then sel 0..7 back-to-back: one word per cycle, values 8'h10..8'h17.
- **Full scan:** mode=1, en_mask=8'hFF, out_ready=1.
  - Required: out_ch 0..7 over 8 consecutive cycles, data 8'h10..8'h17, out_last only on ch 7.
  - Required: changing in_data after accept does not alter the output.
- **Sparse and empty masks:**
  - en_mask=8'b1010_0100: words on ch 2, 5, 7 only; out_last on 7.
  - en_mask=8'h01: single word with out_last=1, stays IDLE.
  - en_mask=0: no out_valid.
- **Backpressure:** full scan with out_ready toggling 1,0,0,1,...
  - Required: outputs hold during stalls, no word lost or duplicated, in_ready=0 throughout SCAN.
- **Overlap:** accept a direct request (sel=3) while the last scan word is stalled.
  - Required: in_ready rises exactly when out_ready=1 on that last word.
  - Required: 8'h13 follows ch 7 with no bubble.
